decode_phase_scheduler: RTL and testbench

Central sequencer for one LDPC decoder column of PE blocks. It sequences the alternating VNU/CNU phases: sweep addresses, pipeline drain gaps, address-generator resets and iteration count. It owns the ping-pong frame select between the intrinsic and decision RAM banks, and handshakes with the intrinsic loader and the hard-decision readout so that a new frame is never decoded over unread results. Its outputs fan out to every PE block and CNU in the array.

---
 rtl/decode_phase_scheduler.sv | 147 ++++++++++++++
 tb/tb_decode_phase_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_phase_scheduler.sv
// Phase sequencer for one LDPC decoder column: alternates VNU/CNU sweeps with drain gaps,
// counts iterations and owns the intrinsic/decision ping-pong bank select.
module decode_phase_scheduler #(
    parameter int L          = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_ITER   = 18,
    parameter int ITER_WIDTH = 5,
    parameter int VNU_DELAY  = 4,
    parameter int CNU_DELAY  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load_done,
    input  logic                  read_done,
    input  logic                  flush,
    output logic                  load_ready,
    output logic                  dec_valid,
    output logic                  rs,
    output logic                  vnu_en,
    output logic                  sweep_active,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output logic                  ag_reset,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  load_overrun
);
    localparam int MAX_DELAY = (VNU_DELAY > CNU_DELAY) ? VNU_DELAY : CNU_DELAY;
    localparam int DW        = $clog2(MAX_DELAY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(L - 1);
    localparam logic [DW-1:0]         VNU_LAST  = DW'(VNU_DELAY - 1);
    localparam logic [DW-1:0]         CNU_LAST  = DW'(CNU_DELAY - 1);
    localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(MAX_ITER - 1);

    typedef enum logic [2:0] {
        S_WAIT, S_SWAP, S_VNU_SWEEP, S_VNU_DRAIN, S_CNU_SWEEP, S_CNU_DRAIN, S_DONE
    } state_t;

    state_t                state, next_state;
    logic [DW-1:0]         drain_cnt, nxt_drain;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [ITER_WIDTH-1:0] nxt_iter;
    logic                  pending, result_pending, flush_only;
    logic                  go_flush, swap_now, load_take, ag_reset_d, frame_done_d;

    // Handshake: load_done/read_done are single-cycle pulses, accepted in any cycle
    // (even while frozen); a load is taken only when load_ready is high or a SWAP
    // frees the bank in the same cycle, otherwise it is flagged as an overrun.
    assign load_ready = ~pending;

    always_comb begin
        next_state = state;
        go_flush   = 1'b0;
        if (enable) begin
            unique case (state)
                S_WAIT: begin
                    if (pending && !dec_valid) begin
                        next_state = S_SWAP;
                    end else if (flush && result_pending && !pending && !dec_valid) begin
                        next_state = S_SWAP;
                        go_flush   = 1'b1;
                    end
                end
                S_SWAP:      next_state = flush_only ? S_WAIT : S_VNU_SWEEP;
                S_VNU_SWEEP: if (sweep_addr == LAST_ADDR) next_state = S_VNU_DRAIN;
                S_VNU_DRAIN: if (drain_cnt == VNU_LAST) next_state = S_CNU_SWEEP;
                S_CNU_SWEEP: if (sweep_addr == LAST_ADDR) next_state = S_CNU_DRAIN;
                S_CNU_DRAIN: begin
                    if (drain_cnt == CNU_LAST)
                        next_state = (iter_count == LAST_ITER) ? S_DONE : S_VNU_SWEEP;
                end
                S_DONE:      next_state = S_WAIT;
                default:     next_state = S_WAIT;
            endcase
        end

        swap_now = (state == S_WAIT) && (next_state == S_SWAP);

        nxt_drain = drain_cnt;
        if (enable) begin
            if ((state == S_VNU_DRAIN || state == S_CNU_DRAIN) && next_state == state)
                nxt_drain = drain_cnt + DW'(1);
            else
                nxt_drain = '0;
        end

        // Address restarts at 0 on every sweep entry and otherwise holds through drains.
        nxt_addr = sweep_addr;
        if (enable && (next_state == S_VNU_SWEEP || next_state == S_CNU_SWEEP))
            nxt_addr = (next_state == state) ? sweep_addr + ADDR_WIDTH'(1) : '0;

        nxt_iter = iter_count;
        if (swap_now)
            nxt_iter = '0;
        else if (enable && state == S_CNU_DRAIN && next_state == S_VNU_SWEEP)
            nxt_iter = iter_count + ITER_WIDTH'(1);

        ag_reset_d   = enable && (swap_now
                       || (next_state == S_VNU_DRAIN && nxt_drain == VNU_LAST)
                       || (next_state == S_CNU_DRAIN && nxt_drain == CNU_LAST));
        frame_done_d = enable && (next_state == S_DONE);
        load_take    = load_done && (!pending || swap_now);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_WAIT;
            drain_cnt      <= '0;
            sweep_addr     <= '0;
            iter_count     <= '0;
            vnu_en         <= 1'b1;
            sweep_active   <= 1'b0;
            busy           <= 1'b0;
            ag_reset       <= 1'b0;
            frame_done     <= 1'b0;
            rs             <= 1'b0;
            flush_only     <= 1'b0;
            pending        <= 1'b0;
            result_pending <= 1'b0;
            dec_valid      <= 1'b0;
            load_overrun   <= 1'b0;
        end else begin
            state        <= next_state;
            drain_cnt    <= nxt_drain;
            sweep_addr   <= nxt_addr;
            iter_count   <= nxt_iter;
            vnu_en       <= !(next_state == S_CNU_SWEEP || next_state == S_CNU_DRAIN);
            sweep_active <= (next_state == S_VNU_SWEEP) || (next_state == S_CNU_SWEEP);
            busy         <= (next_state != S_WAIT);
            ag_reset     <= ag_reset_d;
            frame_done   <= frame_done_d;
            if (swap_now) begin
                rs         <= ~rs;
                flush_only <= go_flush;
            end
            // Set wins over clear for both the load flag and the decision flag.
            if (load_take)     pending <= 1'b1;
            else if (swap_now) pending <= 1'b0;
            if (load_done && pending && !swap_now) load_overrun <= 1'b1;
            if (swap_now)          result_pending <= 1'b0;
            else if (frame_done_d) result_pending <= 1'b1;
            if (swap_now && result_pending) dec_valid <= 1'b1;
            else if (read_done)             dec_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_phase_scheduler.sv
// Bench for decode_phase_scheduler with a small geometry: L=4, MAX_ITER=2, VNU_DELAY=1, CNU_DELAY=2.
module tb_decode_phase_scheduler;
    localparam int L_T   = 4;
    localparam int AW_T  = 3;
    localparam int MI_T  = 2;
    localparam int IW_T  = 3;
    localparam int VD_T  = 1;
    localparam int CD_T  = 2;
    localparam int FRAME_LAT = 2 + MI_T * (2 * L_T + VD_T + CD_T);
    localparam int AGR_PER_FRAME = 1 + 2 * MI_T;
    localparam logic [14:0] RST_OUT = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0,
                                       1'b0, 1'b0, 1'b0};

    logic            clk = 1'b0;
    logic            reset_n, enable, load_done, read_done, flush;
    logic            load_ready, dec_valid, rs, vnu_en, sweep_active, ag_reset;
    logic            busy, frame_done, load_overrun;
    logic [AW_T-1:0] sweep_addr;
    logic [IW_T-1:0] iter_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];
    int         lat_q[$];

    decode_phase_scheduler #(
        .L(L_T), .ADDR_WIDTH(AW_T), .MAX_ITER(MI_T), .ITER_WIDTH(IW_T),
        .VNU_DELAY(VD_T), .CNU_DELAY(CD_T)
    ) dut (
        .clk(clk), .reset(reset_n), .enable(enable), .load_done(load_done),
        .read_done(read_done), .flush(flush), .load_ready(load_ready),
        .dec_valid(dec_valid), .rs(rs), .vnu_en(vnu_en), .sweep_active(sweep_active),
        .sweep_addr(sweep_addr), .ag_reset(ag_reset), .iter_count(iter_count),
        .busy(busy), .frame_done(frame_done), .load_overrun(load_overrun)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {load_ready, dec_valid, rs, busy, ag_reset};
    endfunction

    function automatic logic [14:0] all_out();
        return {load_ready, dec_valid, rs, vnu_en, sweep_active, sweep_addr, ag_reset,
                iter_count, busy, frame_done, load_overrun};
    endfunction

    // Driver tasks
    task automatic step(input logic en, input logic ld, input logic rd, input logic fl);
        enable    = en;
        load_done = ld;
        read_done = rd;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int lat);
        for (int it = 0; it < MI_T; it++) begin
            for (int a = 0; a < L_T; a++) exp_q.push_back({1'b1, 3'(it), 3'(a)});
            for (int a = 0; a < L_T; a++) exp_q.push_back({1'b0, 3'(it), 3'(a)});
        end
        lat_q.push_back(lat);
    endtask

    task automatic wait_frame_done(input int budget);
        int n;
        n = 0;
        while (!frame_done && n < budget) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check("frame_done_seen", frame_done, 1);
    endtask

    // Scoreboard monitor: sweep trace, frame latency and address-generator resets
    logic en_s = 1'b0;
    logic busy_prev = 1'b0;
    int   lat_cnt = 0;
    int   agr_cnt = 0;
    logic [6:0] e;

    always @(posedge clk) en_s = enable;

    always @(negedge clk) begin
        if (!reset_n) begin
            busy_prev = 1'b0;
        end else begin
            if (sweep_active && en_s) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sweep_unexpected: got vnu=%0b iter=%0d addr=%0d required none",
                             vnu_en, iter_count, sweep_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("sweep_trace", {vnu_en, iter_count, sweep_addr}, e);
                end
            end
            if (busy && !busy_prev) begin
                lat_cnt = 1;
                agr_cnt = ag_reset ? 1 : 0;
            end else if (busy) begin
                lat_cnt++;
                if (ag_reset) agr_cnt++;
            end
            if (frame_done) begin
                if (lat_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame_unexpected: got frame_done with no frame queued");
                end else begin
                    check("frame_latency", lat_cnt, lat_q.pop_front());
                    check("ag_reset_count", agr_cnt, AGR_PER_FRAME);
                end
            end
            busy_prev = busy;
        end
    end

    typedef struct packed {
        logic       en;
        logic       ld;
        logic       rd;
        logic       fl;
        logic [4:0] exp;   // {load_ready, dec_valid, rs, busy, ag_reset}
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};  // load frame 1
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10111};  // SWAP
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10110};  // VNU sweep addr 0
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b00110};  // load frame 2 during decode
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00110};

        reset_n = 1'b0; enable = 1'b1; load_done = 1'b0; read_done = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", all_out(), RST_OUT);
        reset_n = 1'b1;

        push_frame(FRAME_LAT);   // frame 1
        push_frame(FRAME_LAT);   // frame 2
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].en, vecs[i].ld, vecs[i].rd, vecs[i].fl);
            check($sformatf("vec%0d_flags", i), flags(), vecs[i].exp);
        end

        wait_frame_done(60);
        check("f1_done_flags", {rs, dec_valid, load_ready}, 3'b100);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("f1_wait", {flags(), frame_done}, 6'b001000);
        push_frame(FRAME_LAT + 5);   // frame 3, loaded in the SWAP cycle, decoded with a pause
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("f2_swap", flags(), 5'b01011);
        check("f2_swap_no_overrun", load_overrun, 0);

        wait_frame_done(60);
        check("f2_done_flags", {rs, dec_valid, load_ready}, 3'b010);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("stall_wait%0d", i), flags(), 5'b01000);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("read_clears", flags(), 5'b00000);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("f3_swap_set_wins", flags(), 5'b11111);

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_start_addr", {sweep_active, sweep_addr}, {1'b1, 3'd2});
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, (i == 2) ? 1'b1 : 1'b0, 1'b0);
            check($sformatf("pause%0d", i), {sweep_active, sweep_addr, ag_reset, frame_done},
                  {1'b1, 3'd2, 1'b0, 1'b0});
        end
        check("read_while_frozen", dec_valid, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_addr", {sweep_active, vnu_en, sweep_addr}, {1'b1, 1'b1, 3'd3});

        wait_frame_done(80);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("flush_wait", busy, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("flush_swap", flags(), 5'b11011);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("flush_back_wait", {flags(), sweep_active}, 6'b110000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("flush_stays_wait", {busy, sweep_active}, 2'b00);

        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("load_accepted", {load_ready, load_overrun}, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("overrun_set", load_overrun, 1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("overrun_sticky", {load_overrun, busy}, 2'b10);
        check("queues_drained", exp_q.size() + lat_q.size(), 0);

        push_frame(FRAME_LAT);   // frame 4, interrupted by reset
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("f4_swap", flags(), 5'b10111);
        repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_cnu_sweep", {vnu_en, sweep_active, sweep_addr}, {1'b0, 1'b1, 3'd1});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", all_out(), RST_OUT);
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("after_reset", all_out(), RST_OUT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
